// File: rtl/parity_checker_stream.sv
// Even-parity checker for a valid/ready codeword stream. It forwards the data nibble and a
// per-word error flag through one registered stage, and keeps error and word statistics.
module parity_checker_stream #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter bit          DROP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              err_out,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  input  logic              clr
);

  logic              acc;
  logic              err;
  logic              load;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              err_out_q, err_out_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_base;
  logic [CNT_W-1:0]  word_cnt_base;

  // The output stage can take a new word whenever its current word leaves this cycle.
  assign din_ready = !dout_valid_q | dout_ready;
  assign acc       = din_valid & din_ready;
  assign err       = ^din;
  assign load      = acc & !(DROP_ERR & err);

  always_comb begin
    dout_d       = dout_q;
    err_out_d    = err_out_q;
    dout_valid_d = dout_valid_q;
    if (load) begin
      dout_d       = din[DATA_W:1];
      err_out_d    = err;
      dout_valid_d = 1'b1;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // clr zeroes the statistics first, so an accept in the same cycle is still counted.
  always_comb begin
    err_cnt_base  = clr ? '0 : err_cnt_q;
    word_cnt_base = clr ? '0 : word_cnt_q;
    word_cnt_d    = word_cnt_base;
    err_cnt_d     = err_cnt_base;
    err_sticky_d  = clr ? 1'b0 : err_sticky_q;
    if (acc) begin
      word_cnt_d = word_cnt_base + CNT_W'(1);
      if (err) begin
        err_sticky_d = 1'b1;
        if (err_cnt_base != {CNT_W{1'b1}}) begin
          err_cnt_d = err_cnt_base + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_out_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      word_cnt_q   <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_out_q    <= err_out_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err_out    = err_out_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_parity_checker_stream.sv
// Scoreboard bench for parity_checker_stream: forwarding, drop mode and narrow-counter
// saturation, each on its own instance.
module tb_parity_checker_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Main instance: DROP_ERR=0, CNT_W=8.
  logic [4:0] m_din = '0;
  logic       m_din_valid = 1'b0, m_din_ready, m_dout_valid, m_dout_ready = 1'b1;
  logic [3:0] m_dout;
  logic       m_err_out, m_err_sticky, m_clr = 1'b0;
  logic [7:0] m_err_cnt, m_word_cnt;

  parity_checker_stream #(.DATA_W(4), .CNT_W(8), .DROP_ERR(1'b0)) u_main (
    .clk(clk), .rst(rst), .din(m_din), .din_valid(m_din_valid), .din_ready(m_din_ready),
    .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(m_dout_ready), .err_out(m_err_out),
    .err_sticky(m_err_sticky), .err_cnt(m_err_cnt), .word_cnt(m_word_cnt), .clr(m_clr)
  );

  // Drop instance: DROP_ERR=1.
  logic [4:0] d_din = '0;
  logic       d_din_valid = 1'b0, d_din_ready, d_dout_valid, d_dout_ready = 1'b1;
  logic [3:0] d_dout;
  logic       d_err_out, d_err_sticky;
  logic [7:0] d_err_cnt, d_word_cnt;

  parity_checker_stream #(.DATA_W(4), .CNT_W(8), .DROP_ERR(1'b1)) u_drop (
    .clk(clk), .rst(rst), .din(d_din), .din_valid(d_din_valid), .din_ready(d_din_ready),
    .dout(d_dout), .dout_valid(d_dout_valid), .dout_ready(d_dout_ready), .err_out(d_err_out),
    .err_sticky(d_err_sticky), .err_cnt(d_err_cnt), .word_cnt(d_word_cnt), .clr(1'b0)
  );

  // Narrow-counter instance: CNT_W=2.
  logic [4:0] s_din = '0;
  logic       s_din_valid = 1'b0, s_din_ready, s_dout_valid;
  logic [3:0] s_dout;
  logic       s_err_out, s_err_sticky;
  logic [1:0] s_err_cnt, s_word_cnt;

  parity_checker_stream #(.DATA_W(4), .CNT_W(2), .DROP_ERR(1'b0)) u_sat (
    .clk(clk), .rst(rst), .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
    .dout(s_dout), .dout_valid(s_dout_valid), .dout_ready(1'b1), .err_out(s_err_out),
    .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt), .clr(1'b0)
  );

  // Expected {data, err} per forwarded word.
  logic [4:0] m_q[$];
  logic [4:0] d_q[$];

  always @(negedge clk) begin
    if (!rst && m_dout_valid && m_dout_ready) begin
      if (m_q.size() == 0) begin
        check("main_unexpected_word", {m_dout, m_err_out}, 5'h1f);
      end else begin
        logic [4:0] e;
        e = m_q.pop_front();
        check("main_dout", m_dout, e[4:1]);
        check("main_err_out", m_err_out, e[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d_dout_valid && d_dout_ready) begin
      if (d_q.size() == 0) begin
        check("drop_unexpected_word", {d_dout, d_err_out}, 5'h1f);
      end else begin
        logic [4:0] e;
        e = d_q.pop_front();
        check("drop_dout", d_dout, e[4:1]);
        check("drop_err_out", d_err_out, e[0]);
      end
    end
  end

  // Present a codeword, wait (bounded) for acceptance and queue its hand-computed result.
  task automatic m_send(input logic [4:0] w, input logic [3:0] exp_d, input logic exp_e);
    bit ok = 1'b0;
    m_din = w;
    m_din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("main_accept_timeout", ok, 1'b1);
    if (ok) m_q.push_back({exp_d, exp_e});
    @(posedge clk);
    #1;
    m_din_valid = 1'b0;
  endtask

  task automatic d_send(input logic [4:0] w, input bit fwd, input logic [3:0] exp_d);
    bit ok = 1'b0;
    d_din = w;
    d_din_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("drop_accept_timeout", ok, 1'b1);
    if (ok && fwd) d_q.push_back({exp_d, 1'b0});
    @(posedge clk);
    #1;
    d_din_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [1:0] sat_err_exp[5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] sat_word_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout", m_dout, 4'h0);
    check("reset_dout_valid", m_dout_valid, 1'b0);
    check("reset_err_out", m_err_out, 1'b0);
    check("reset_err_sticky", m_err_sticky, 1'b0);
    check("reset_err_cnt", m_err_cnt, 8'd0);
    check("reset_word_cnt", m_word_cnt, 8'd0);
    check("reset_din_ready", m_din_ready, 1'b1);

    // Drop mode: {0010,0} has odd weight and is dropped.
    @(posedge clk);
    #1;
    d_send(5'b0010_0, 1'b0, 4'b0010);
    d_send(5'b0010_1, 1'b1, 4'b0010);
    d_send(5'b0100_1, 1'b1, 4'b0100);
    repeat (2) @(negedge clk);
    check("drop_err_cnt", d_err_cnt, 8'd1);
    check("drop_word_cnt", d_word_cnt, 8'd3);
    check("drop_err_sticky", d_err_sticky, 1'b1);
    check("drop_queue_drained", d_q.size(), 0);

    // Saturation and wrap with 2-bit counters: five erroneous words back to back.
    @(posedge clk);
    #1;
    s_din = 5'b0000_1;
    s_din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sat_din_ready", s_din_ready, 1'b1);
      @(posedge clk);
      #1;
      check("sat_err_cnt", s_err_cnt, sat_err_exp[i]);
      check("sat_word_cnt", s_word_cnt, sat_word_exp[i]);
      check("sat_err_out", s_err_out, 1'b1);
    end
    s_din_valid = 1'b0;

    // Clean stream, back to back.
    m_send(5'b0001_1, 4'b0001, 1'b0);
    m_send(5'b0011_0, 4'b0011, 1'b0);
    m_send(5'b1111_0, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    check("clean_word_cnt", m_word_cnt, 8'd3);
    check("clean_err_cnt", m_err_cnt, 8'd0);
    check("clean_err_sticky", m_err_sticky, 1'b0);

    // Single error, then a good word: sticky stays set.
    @(posedge clk);
    #1;
    m_send(5'b0101_1, 4'b0101, 1'b1);
    @(negedge clk);
    check("err_err_cnt", m_err_cnt, 8'd1);
    check("err_err_sticky", m_err_sticky, 1'b1);
    @(posedge clk);
    #1;
    m_send(5'b0101_0, 4'b0101, 1'b0);
    @(negedge clk);
    check("err_sticky_hold", m_err_sticky, 1'b1);
    check("err_word_cnt", m_word_cnt, 8'd5);

    // Backpressure: 1000 held for 3 cycles, next word blocked, then accepted with no bubble.
    @(posedge clk);
    #1;
    m_dout_ready = 1'b0;
    m_send(5'b1000_1, 4'b1000, 1'b0);
    m_din = 5'b0011_0;
    m_din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_din_ready", m_din_ready, 1'b0);
      check("bp_dout_hold", m_dout, 4'b1000);
      check("bp_dout_valid", m_dout_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    check("bp_word_cnt_blocked", m_word_cnt, 8'd6);
    m_dout_ready = 1'b1;
    @(negedge clk);
    check("bp_din_ready_release", m_din_ready, 1'b1);
    m_q.push_back({4'b0011, 1'b0});
    @(posedge clk);
    #1;
    m_din_valid = 1'b0;
    @(negedge clk);
    check("bp_next_dout", m_dout, 4'b0011);
    check("bp_word_cnt", m_word_cnt, 8'd7);

    // clr together with an accepted erroneous word.
    @(posedge clk);
    #1;
    m_clr = 1'b1;
    m_send(5'b1110_0, 4'b1110, 1'b1);
    m_clr = 1'b0;
    check("clr_acc_err_cnt", m_err_cnt, 8'd1);
    check("clr_acc_word_cnt", m_word_cnt, 8'd1);
    check("clr_acc_err_sticky", m_err_sticky, 1'b1);

    // clr together with an accepted good word.
    m_clr = 1'b1;
    m_send(5'b0110_0, 4'b0110, 1'b0);
    m_clr = 1'b0;
    check("clr_good_err_cnt", m_err_cnt, 8'd0);
    check("clr_good_word_cnt", m_word_cnt, 8'd1);
    check("clr_good_err_sticky", m_err_sticky, 1'b0);

    // clr alone.
    m_clr = 1'b1;
    @(posedge clk);
    #1;
    m_clr = 1'b0;
    check("clr_word_cnt", m_word_cnt, 8'd0);

    // Reset while a word is held; the word presented during reset is not counted.
    m_dout_ready = 1'b0;
    m_send(5'b0001_0, 4'b0001, 1'b1);
    @(negedge clk);
    check("rst_pre_valid", m_dout_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_din = 5'b0111_1;
    m_din_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_din_valid = 1'b0;
    m_q.delete();
    @(negedge clk);
    check("rst_dout", m_dout, 4'h0);
    check("rst_dout_valid", m_dout_valid, 1'b0);
    check("rst_err_out", m_err_out, 1'b0);
    check("rst_err_sticky", m_err_sticky, 1'b0);
    check("rst_err_cnt", m_err_cnt, 8'd0);
    check("rst_word_cnt", m_word_cnt, 8'd0);
    check("rst_din_ready", m_din_ready, 1'b1);
    m_dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("main_queue_drained", m_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_checker_stream.md
Name: parity_checker_stream

Overview:
- Downstream consumer of the 4-bit even-parity encoder: accepts 5-bit codewords over a valid/ready stream and recomputes parity.
- Forwards the data nibble with a per-word error flag through a single registered output stage with backpressure.
- Keeps a saturating error counter, a total-word counter and a sticky error flag for status readout.
- Optionally drops erroneous words instead of forwarding them.

Parameters:
- DATA_W, 4, data bits per codeword; codeword width is DATA_W+1.
- CNT_W, 8, width of the error and word counters.
- DROP_ERR, 0, 1 = words with a parity error are counted but not forwarded; 0 = forwarded with err_out=1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- din  in  DATA_W+1  codeword; din[DATA_W:1] = data, din[0] = parity bit (even parity over all DATA_W+1 bits).
- din_valid  in  1  codeword present on din.
- din_ready  out  1  checker can accept a codeword this cycle.
- dout  out  DATA_W  registered data nibble.
- dout_valid  out  1  dout/err_out hold a word.
- dout_ready  in  1  downstream accepts the word.
- err_out  out  1  parity error on the word currently on dout.
- err_sticky  out  1  set on any accepted erroneous word; cleared only by rst or clr.
- err_cnt  out  CNT_W  accepted erroneous words, saturating.
- word_cnt  out  CNT_W  accepted words, wrapping modulo 2^CNT_W.
- clr  in  1  synchronous clear of err_sticky, err_cnt and word_cnt.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: dout=0, dout_valid=0, err_out=0, err_sticky=0, err_cnt=0, word_cnt=0. din_ready=1 in the first cycle after reset.
- Accept condition: acc = din_valid & din_ready.
- Ready rule: din_ready = !dout_valid | dout_ready. This is combinational, with no bubble on continuous flow.
- Error detection: err = XOR-reduce of din[DATA_W:0]. err=1 means odd total weight, i.e. a parity error.
- Latency: one cycle. A word accepted at edge N appears on dout/err_out with dout_valid=1 after edge N.
- Hold while stalled: dout, err_out and dout_valid hold while dout_valid & !dout_ready.
- Output update on acc:
  - If DROP_ERR=1 and err=1, no output is loaded. dout_valid becomes 0 if the held word was taken (dout_ready=1), otherwise it is unchanged.
  - Otherwise dout <= din[DATA_W:1], err_out <= err, dout_valid <= 1.
- No accept: dout_valid & dout_ready -> dout_valid <= 0. dout and err_out keep their stale values.
- word_cnt: +1 on every acc, including dropped words. Wraps from 2^CNT_W-1 to 0.
- err_cnt: +1 on acc & err. Saturates at 2^CNT_W-1 and never wraps.
- err_sticky: set on acc & err.
- clr alone: err_cnt=0, err_sticky=0, word_cnt=0.
- clr with a simultaneous acc: the event is not lost. word_cnt=1; if err then err_cnt=1 and err_sticky=1, else err_cnt=0 and err_sticky=0.
- clr does not affect the data path.
- rst mid-stream: the held output word is discarded (dout_valid=0) and all counters zero. An input word presented in the reset cycle is not accepted and not counted.
- din is ignored when din_valid=0. There are no X-propagation requirements beyond that.

Test Plan:
- Clean stream: din = {0001,1}, {0011,0}, {1111,0}, each with din_valid=1 and dout_ready=1 -> dout = 0001, 0011, 1111 one cycle later; err_out=0 each; word_cnt=3; err_cnt=0; err_sticky=0.
- Single error, DROP_ERR=0: din={0101,1} -> dout=0101, err_out=1, err_cnt=1, err_sticky=1. A following din={0101,0} -> err_out=0, err_sticky stays 1.
- Backpressure: dout_ready=0 while din={1000,1} is held on dout -> din_ready=0, dout stays 1000 for 3 cycles and the next word is not accepted. Raise dout_ready -> next word accepted in the same cycle, no bubble.
- Drop mode, DROP_ERR=1: send {0010,0}, {0010,1}, {0100,1} -> only 0010 and 0100 appear on dout; err_cnt=1; word_cnt=3.
- Saturation and wrap, CNT_W=2: send 5 erroneous words -> err_cnt = 1, 2, 3, 3, 3; word_cnt = 1, 2, 3, 0, 1.
- clr and reset: assert clr with an accepted erroneous word -> err_cnt=1, word_cnt=1, err_sticky=1. Then assert rst while dout_valid=1 -> all outputs 0 the next cycle and din_ready=1.
